// File: rtl/pixel_write_arbiter_if.sv
// Pixel write port bundle between the sprite drawers (master side) and the
// shared-port arbiter (slave side).
interface pixel_write_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*9-1:0]  x_in;
  logic [N_REQ*8-1:0]  y_in;
  logic [N_REQ*12-1:0] color_in;
  logic [N_REQ-1:0]    we_in;
  logic [N_REQ-1:0]    grant;
  logic [1:0]          active_id;
  logic                busy;
  logic [8:0]          X_out;
  logic [7:0]          Y_out;
  logic [11:0]         Color_out;
  logic                writeEn;
  logic                timeout_err;

  modport master (
    output req, x_in, y_in, color_in, we_in,
    input  grant, active_id, busy, X_out, Y_out, Color_out, writeEn, timeout_err
  );

  modport slave (
    input  req, x_in, y_in, color_in, we_in,
    output grant, active_id, busy, X_out, Y_out, Color_out, writeEn, timeout_err
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Fixed-priority, burst-locked arbiter for the single VGA pixel write port, with
// a hold-time watchdog. Define PIXEL_ARB_TRANSPARENT_EN to suppress black pixels.
module pixel_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 131072,
  parameter int HOLD_W   = 17
) (
  input logic                  clk,
  input logic                  reset,
  pixel_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    mask_q, mask_d;
  logic [1:0]          active_id_q, active_id_d;
  logic                busy_q, busy_d;
  logic                write_en_q, write_en_d;
  logic                timeout_err_q, timeout_err_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [11:0]         color_q, color_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0]    eligible;
  logic [1:0]          pick_id;
  logic                owner_req;
  logic [8:0]          sel_x;
  logic [7:0]          sel_y;
  logic [11:0]         sel_color;
  logic                sel_we;

  function automatic logic [1:0] lowest_index(input logic [N_REQ-1:0] v);
    lowest_index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = 2'(i);
    end
  endfunction

  // A revoked requester stays ineligible until it has dropped req once.
  assign eligible  = bus.req & ~mask_q;
  assign pick_id   = lowest_index(eligible);
  assign owner_req = bus.req[active_id_q];
  assign sel_x     = bus.x_in[9*int'(active_id_q) +: 9];
  assign sel_y     = bus.y_in[8*int'(active_id_q) +: 8];
  assign sel_color = bus.color_in[12*int'(active_id_q) +: 12];

`ifdef PIXEL_ARB_TRANSPARENT_EN
  assign sel_we = bus.we_in[active_id_q] & (sel_color != 12'h000);
`else
  assign sel_we = bus.we_in[active_id_q];
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    active_id_d   = active_id_q;
    busy_d        = busy_q;
    write_en_d    = 1'b0;
    timeout_err_d = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    hold_cnt_d    = hold_cnt_q;
    mask_d        = mask_q & bus.req;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d     = HOLD;
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
          active_id_d = pick_id;
          busy_d      = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      HOLD: begin
        // A dropped request takes precedence over the watchdog firing.
        if (!owner_req) begin
          state_d = RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d              = RELEASE;
          grant_d              = '0;
          busy_d               = 1'b0;
          timeout_err_d        = 1'b1;
          mask_d[active_id_q]  = 1'b1;
        end else begin
          x_d        = sel_x;
          y_d        = sel_y;
          color_d    = sel_color;
          write_en_d = sel_we;
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      mask_q        <= '0;
      active_id_q   <= '0;
      busy_q        <= 1'b0;
      write_en_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      mask_q        <= mask_d;
      active_id_q   <= active_id_d;
      busy_q        <= busy_d;
      write_en_q    <= write_en_d;
      timeout_err_q <= timeout_err_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.active_id   = active_id_q;
  assign bus.busy        = busy_q;
  assign bus.X_out       = x_q;
  assign bus.Y_out       = y_q;
  assign bus.Color_out   = color_q;
  assign bus.writeEn     = write_en_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed scenarios plus random traffic, checked
// every cycle against a burst-ownership reference model.
module tb_pixel_write_arbiter;
  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = 4;
`ifdef PIXEL_ARB_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_write_arbiter_if #(.N_REQ(N_REQ)) bus ();

  pixel_write_arbiter #(
    .N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, how long, and the inter-burst gap.
  int         m_owner;
  int         m_age;
  bit         m_gap;
  bit         m_mask [N_REQ];
  logic [8:0] e_x;
  logic [7:0] e_y;
  logic [11:0] e_c;
  bit         e_we;
  bit         e_to;
  int         e_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_gap = 1'b0;
    for (int i = 0; i < N_REQ; i++) m_mask[i] = 1'b0;
    e_x = '0; e_y = '0; e_c = '0; e_we = 1'b0; e_to = 1'b0; e_id = 0;
  endtask

  task automatic model_step();
    logic [N_REQ-1:0] r;
    bit found;
    r = bus.req;
    e_we = 1'b0;
    e_to = 1'b0;
    found = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1'b1;
      end else if (m_age == MAX_HOLD - 1) begin
        m_mask[m_owner] = 1'b1; e_to = 1'b1; m_owner = -1; m_gap = 1'b1;
      end else begin
        e_x  = bus.x_in[9*m_owner +: 9];
        e_y  = bus.y_in[8*m_owner +: 8];
        e_c  = bus.color_in[12*m_owner +: 12];
        e_we = bus.we_in[m_owner] && (!TRANSP || e_c != 12'h000);
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && r[i] && !m_mask[i]) begin
          found = 1'b1; m_owner = i; m_age = 0; e_id = i;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) if (!r[i]) m_mask[i] = 1'b0;
  endtask

  task automatic compare_all();
    check("grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check("active_id", 32'(bus.active_id), 32'(e_id));
    check("writeEn", 32'(bus.writeEn), 32'(e_we));
    check("timeout_err", 32'(bus.timeout_err), 32'(e_to));
    check("X_out", 32'(bus.X_out), 32'(e_x));
    check("Y_out", 32'(bus.Y_out), 32'(e_y));
    check("Color_out", 32'(bus.Color_out), 32'(e_c));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_REQ; i++) begin
      bus.x_in[9*i +: 9]      = 9'($urandom);
      bus.y_in[8*i +: 8]      = 8'($urandom);
      bus.color_in[12*i +: 12] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    end
    bus.we_in = 4'($urandom);
  endtask

  initial begin
    int pulses;
    int seen_to;
    reset   = 1'b1;
    bus.req = '0;
    rand_data();
    model_reset();
    #12;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_writeEn", 32'(bus.writeEn), 32'd0);
    check("rst_X_out", 32'(bus.X_out), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single requester burst
    bus.req = 4'b0001;
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      rand_data();
      bus.we_in[0] = 1'b1;
      bus.color_in[0] = 1'b1;
      tick();
      if (k == 0) check("t1_grant", 32'(bus.grant), 32'h1);
      pulses += int'(bus.writeEn);
    end
    check("t1_pulses", 32'(pulses), 32'd10);
    bus.req = '0;
    tick();
    check("t1_release_busy", 32'(bus.busy), 32'd0);
    tick();

    // 2: simultaneous requests, priority order
    bus.req = 4'b1010;
    tick();
    check("t2_first", 32'(bus.grant), 32'b0010);
    repeat (4) begin rand_data(); tick(); end
    bus.req = 4'b1000;
    tick();
    check("t2_dead1", 32'(bus.grant), 32'd0);
    tick();
    check("t2_dead2", 32'(bus.grant), 32'd0);
    tick();
    check("t2_second", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    repeat (3) tick();

    // 3: no preemption by higher priority
    bus.req = 4'b0100;
    tick();
    check("t3_grant2", 32'(bus.grant), 32'b0100);
    tick();
    bus.req = 4'b0101;
    repeat (3) begin
      rand_data();
      tick();
      check("t3_no_preempt", 32'(bus.grant), 32'b0100);
    end
    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    check("t3_grant0", 32'(bus.grant), 32'b0001);
    bus.req = '0;
    repeat (3) tick();

    // 4: watchdog revoke and re-request
    bus.req = 4'b1000;
    seen_to = 0;
    for (int k = 0; k < MAX_HOLD + 6; k++) begin
      rand_data();
      tick();
      seen_to += int'(bus.timeout_err);
    end
    check("t4_timeouts", 32'(seen_to), 32'd1);
    check("t4_no_regrant", 32'(bus.grant), 32'd0);
    bus.req = '0;
    tick();
    tick();
    bus.req = 4'b1000;
    tick();
    check("t4_regrant", 32'(bus.grant), 32'b1000);
    repeat (MAX_HOLD - 1) begin rand_data(); tick(); end
    bus.req = '0;
    tick();
    check("t4_drop_wins", 32'(bus.timeout_err), 32'd0);
    tick();
    bus.req = 4'b1000;
    tick();
    check("t4_unmasked", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    repeat (2) tick();

    // 5: black pixel handling
    bus.req = 4'b0001;
    rand_data();
    tick();
    bus.we_in[0] = 1'b1;
    bus.color_in[11:0] = 12'h000;
    tick();
    check("t5_black", 32'(bus.writeEn), TRANSP ? 32'd0 : 32'd1);
    bus.color_in[11:0] = 12'hF00;
    tick();
    check("t5_red", 32'(bus.writeEn), 32'd1);
    bus.req = '0;
    repeat (2) tick();

    // 6: asynchronous reset in the middle of a burst
    bus.req = 4'b0010;
    rand_data();
    bus.we_in = 4'b1111;
    bus.color_in[23:12] = 12'h0F0;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_writeEn", 32'(bus.writeEn), 32'd0);
    check("t6_X_out", 32'(bus.X_out), 32'd0);
    check("t6_Color_out", 32'(bus.Color_out), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t6_restart", 32'(bus.grant), 32'b0010);
    bus.req = '0;
    repeat (2) tick();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      rand_data();
      tick();
    end
    bus.req = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
